// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_pkg
//  Description : Shared BCD types, constants and helpers for the BCD counter
//                family.
//                  bcd_digit_t - one BCD nibble
//                  BCD_MAX     - largest legal digit value (9)
//                  bcd_clamp() - saturates an arbitrary nibble to 0..9
//  Revision    : 1.0 - initial release
// ============================================================================
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;

    // Nibbles 10..15 are not legal BCD; map them onto the nearest legal value.
    function automatic bcd_digit_t bcd_clamp(input bcd_digit_t nibble);
        return (nibble > BCD_MAX) ? BCD_MAX : nibble;
    endfunction

endpackage : bcd_pkg
`default_nettype wire

// File: rtl/bcd_digit_step.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_digit_step
//  Description : Purely combinational single-digit BCD increment/decrement
//                stage, chained through cin/cout to build a ripple counter.
//  Ports       : digit      in  4  current BCD digit (always legal, 0..9)
//                cin        in  1  carry (up) or borrow (down) from lower digit
//                up         in  1  1 = add cin, 0 = subtract cin
//                next_digit out 4  resulting digit
//                cout       out 1  carry/borrow into the next digit
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit_step
    import bcd_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       cin,
    input  logic       up,
    output logic [3:0] next_digit,
    output logic       cout
);

    always_comb begin
        next_digit = digit;
        cout       = 1'b0;
        if (cin) begin
            if (up) begin
                if (digit == BCD_MAX) begin
                    next_digit = 4'd0;
                    cout       = 1'b1;
                end else begin
                    next_digit = digit + 4'd1;
                end
            end else begin
                if (digit == 4'd0) begin
                    next_digit = BCD_MAX;
                    cout       = 1'b1;
                end else begin
                    next_digit = digit - 4'd1;
                end
            end
        end
    end

endmodule : bcd_digit_step
`default_nettype wire

// File: rtl/bcd_updown_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_updown_cnt
//  Description : Parametrised N-digit BCD up/down counter with parallel load,
//                wrap or saturate at the boundaries, a one-cycle rollover
//                pulse for cascading and a sticky illegal-load error flag.
//  Parameters  : DIGITS   number of BCD digits (1..8)
//                SATURATE 0 = wrap at the boundaries, 1 = hold at max/min
//  Ports       : CLK      in  1          rising-edge clock
//                RST      in  1          asynchronous active-high reset
//                CLR_CNT  in  1          synchronous clear of count and ERR
//                LD       in  1          synchronous parallel load
//                LD_VAL   in  4*DIGITS   load value, digit i at [4i+3:4i]
//                INC      in  1          count up
//                DEC      in  1          count down
//                CNT      out 4*DIGITS   registered BCD count
//                ROLL     out 1          boundary crossing / saturation pulse
//                ERR      out 1          sticky: a load had a nibble > 9
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_updown_cnt
    import bcd_pkg::*;
#(
    parameter int DIGITS   = 2,
    parameter int SATURATE = 0
)(
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  CLR_CNT,
    input  logic                  LD,
    input  logic [4*DIGITS-1:0]   LD_VAL,
    input  logic                  INC,
    input  logic                  DEC,
    output logic [4*DIGITS-1:0]   CNT,
    output logic                  ROLL,
    output logic                  ERR
);

    localparam int c_W = 4 * DIGITS;

    logic [c_W-1:0]  r_cnt;
    logic            r_roll;
    logic            r_err;

    logic [DIGITS:0] w_carry;
    logic [c_W-1:0]  w_step;
    logic            w_boundary;
    logic [c_W-1:0]  w_next_cnt;
    logic [c_W-1:0]  w_ld_cnt;
    logic            w_ld_err;

    // The least significant digit always receives the +/-1 request; the
    // direction only matters when exactly one of INC/DEC is set.
    assign w_carry[0] = 1'b1;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            bcd_digit_step u_step (
                .digit      (r_cnt[4*gi +: 4]),
                .cin        (w_carry[gi]),
                .up         (INC),
                .next_digit (w_step[4*gi +: 4]),
                .cout       (w_carry[gi+1])
            );
        end
    endgenerate

    // A carry/borrow out of the top digit means the count crossed all-9s
    // (up) or zero (down).
    assign w_boundary = w_carry[DIGITS];
    assign w_next_cnt = (w_boundary && (SATURATE != 0)) ? r_cnt : w_step;

    always_comb begin
        w_ld_cnt = '0;
        w_ld_err = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            w_ld_cnt[4*i +: 4] = bcd_clamp(LD_VAL[4*i +: 4]);
            if (LD_VAL[4*i +: 4] > BCD_MAX) begin
                w_ld_err = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cnt  <= '0;
            r_roll <= 1'b0;
            r_err  <= 1'b0;
        end else if (CLR_CNT) begin
            r_cnt  <= '0;
            r_roll <= 1'b0;
            r_err  <= 1'b0;
        end else if (LD) begin
            r_cnt  <= w_ld_cnt;
            r_roll <= 1'b0;
            r_err  <= r_err | w_ld_err;
        end else if (INC ^ DEC) begin
            r_cnt  <= w_next_cnt;
            r_roll <= w_boundary;
        end else begin
            r_roll <= 1'b0;
        end
    end

    assign CNT  = r_cnt;
    assign ROLL = r_roll;
    assign ERR  = r_err;

endmodule : bcd_updown_cnt
`default_nettype wire

// File: tb/tb_bcd_updown_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_updown_cnt
//  Description : Self-checking bench for bcd_updown_cnt. Three instances
//                share one set of stimulus: 2-digit wrap, 2-digit saturate
//                and 4-digit wrap. Each phase checks only the instance it
//                targets.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_updown_cnt;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr_cnt;
    logic        ld;
    logic [15:0] ld_val;
    logic        inc;
    logic        dec;

    logic [7:0]  cnt_w;
    logic        roll_w;
    logic        err_w;
    logic [7:0]  cnt_s;
    logic        roll_s;
    logic        err_s;
    logic [15:0] cnt_4;
    logic        roll_4;
    logic        err_4;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    bcd_updown_cnt #(.DIGITS(2), .SATURATE(0)) dut_w (
        .CLK(clk), .RST(rst), .CLR_CNT(clr_cnt), .LD(ld), .LD_VAL(ld_val[7:0]),
        .INC(inc), .DEC(dec), .CNT(cnt_w), .ROLL(roll_w), .ERR(err_w)
    );

    bcd_updown_cnt #(.DIGITS(2), .SATURATE(1)) dut_s (
        .CLK(clk), .RST(rst), .CLR_CNT(clr_cnt), .LD(ld), .LD_VAL(ld_val[7:0]),
        .INC(inc), .DEC(dec), .CNT(cnt_s), .ROLL(roll_s), .ERR(err_s)
    );

    bcd_updown_cnt #(.DIGITS(4), .SATURATE(0)) dut_4 (
        .CLK(clk), .RST(rst), .CLR_CNT(clr_cnt), .LD(ld), .LD_VAL(ld_val),
        .INC(inc), .DEC(dec), .CNT(cnt_4), .ROLL(roll_4), .ERR(err_4)
    );

    typedef struct {
        logic       clr;
        logic       ld;
        logic [7:0] val;
        logic       inc;
        logic       dec;
        logic [7:0] exp_cnt;
        logic       exp_roll;
        logic       exp_err;
    } vec_t;

    localparam int N_VEC = 18;
    vec_t vecs [N_VEC];

    function automatic vec_t mk(input logic c, input logic l, input logic [7:0] v,
                                input logic i, input logic d, input logic [7:0] ec,
                                input logic er, input logic ee);
        vec_t t;
        t.clr = c; t.ld = l; t.val = v; t.inc = i; t.dec = d;
        t.exp_cnt = ec; t.exp_roll = er; t.exp_err = ee;
        return t;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic c, input logic l, input logic [15:0] v,
                         input logic i, input logic d);
        clr_cnt = c; ld = l; ld_val = v; inc = i; dec = d;
    endtask

    // Apply the currently driven inputs on the next rising edge, then sample
    // 1 time unit later, well away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);

        vecs[0]  = mk(0, 1, 8'h10, 0, 0, 8'h10, 0, 0);
        vecs[1]  = mk(0, 0, 8'h00, 0, 1, 8'h09, 0, 0);
        vecs[2]  = mk(0, 1, 8'h00, 0, 0, 8'h00, 0, 0);
        vecs[3]  = mk(0, 0, 8'h00, 0, 1, 8'h99, 1, 0);
        vecs[4]  = mk(0, 0, 8'h00, 0, 0, 8'h99, 0, 0);
        vecs[5]  = mk(0, 1, 8'hA5, 0, 0, 8'h95, 0, 1);
        vecs[6]  = mk(0, 1, 8'h12, 0, 0, 8'h12, 0, 1);
        vecs[7]  = mk(1, 0, 8'h00, 0, 0, 8'h00, 0, 0);
        vecs[8]  = mk(1, 1, 8'h42, 1, 0, 8'h00, 0, 0);
        vecs[9]  = mk(0, 1, 8'h42, 1, 0, 8'h42, 0, 0);
        vecs[10] = mk(0, 0, 8'h00, 1, 1, 8'h42, 0, 0);
        vecs[11] = mk(0, 0, 8'h00, 1, 0, 8'h43, 0, 0);
        vecs[12] = mk(0, 0, 8'h00, 0, 1, 8'h42, 0, 0);
        vecs[13] = mk(0, 1, 8'h99, 0, 0, 8'h99, 0, 0);
        vecs[14] = mk(0, 0, 8'h00, 1, 0, 8'h00, 1, 0);
        vecs[15] = mk(0, 0, 8'h00, 1, 0, 8'h01, 0, 0);
        vecs[16] = mk(0, 1, 8'h0F, 0, 0, 8'h09, 0, 1);
        vecs[17] = mk(1, 0, 8'h00, 0, 0, 8'h00, 0, 0);

        // Reset state, held across edges.
        step();
        step();
        chk("reset_cnt",  {8'h00, cnt_w}, 16'h0000);
        chk("reset_roll", {15'd0, roll_w}, 16'h0000);
        chk("reset_err",  {15'd0, err_w}, 16'h0000);
        rst = 1'b0;

        // Asynchronous reset mid-count at 37, also clearing ERR.
        drive(0, 1, 16'h00A6, 0, 0);
        step();
        drive(0, 0, 16'h0000, 1, 0);
        step();
        chk("pre_rst_cnt", {8'h00, cnt_w}, 16'h0097);
        drive(0, 1, 16'h0036, 0, 0);
        step();
        drive(0, 0, 16'h0000, 1, 0);
        step();
        chk("pre_rst_37", {8'h00, cnt_w}, 16'h0037);
        chk("pre_rst_err", {15'd0, err_w}, 16'h0001);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_cnt", {8'h00, cnt_w}, 16'h0000);
        chk("async_rst_err", {15'd0, err_w}, 16'h0000);
        chk("async_rst_roll", {15'd0, roll_w}, 16'h0000);
        drive(0, 1, 16'h0021, 1, 0);
        step();
        chk("rst_beats_ld", {8'h00, cnt_w}, 16'h0000);
        rst = 1'b0;
        drive(0, 1, 16'h0021, 0, 0);
        step();
        chk("first_edge_after_rst", {8'h00, cnt_w}, 16'h0021);

        // Table vectors on the 2-digit wrapping counter.
        drive(1, 0, 16'h0000, 0, 0);
        step();
        for (int k = 0; k < N_VEC; k++) begin
            drive(vecs[k].clr, vecs[k].ld, {8'h00, vecs[k].val}, vecs[k].inc, vecs[k].dec);
            step();
            chk($sformatf("vec%0d_cnt", k),  {8'h00, cnt_w}, {8'h00, vecs[k].exp_cnt});
            chk($sformatf("vec%0d_roll", k), {15'd0, roll_w}, {15'd0, vecs[k].exp_roll});
            chk($sformatf("vec%0d_err", k),  {15'd0, err_w}, {15'd0, vecs[k].exp_err});
        end

        // 100 increments from zero: 01..99 then 00 with a single ROLL.
        drive(1, 0, 16'h0000, 0, 0);
        step();
        drive(0, 0, 16'h0000, 1, 0);
        for (int i = 1; i <= 100; i++) begin
            int v;
            logic [7:0] e;
            v = i % 100;
            e = {4'(v / 10), 4'(v % 10)};
            step();
            chk($sformatf("inc100_cnt_%0d", i), {8'h00, cnt_w}, {8'h00, e});
            chk($sformatf("inc100_roll_%0d", i), {15'd0, roll_w}, {15'd0, (i == 100)});
        end

        // Saturating counter at both boundaries.
        drive(0, 1, 16'h0098, 0, 0);
        step();
        chk("sat_ld98", {8'h00, cnt_s}, 16'h0098);
        drive(0, 0, 16'h0000, 1, 0);
        step();
        chk("sat_inc1_cnt", {8'h00, cnt_s}, 16'h0099);
        chk("sat_inc1_roll", {15'd0, roll_s}, 16'h0000);
        step();
        chk("sat_inc2_cnt", {8'h00, cnt_s}, 16'h0099);
        chk("sat_inc2_roll", {15'd0, roll_s}, 16'h0001);
        step();
        chk("sat_inc3_cnt", {8'h00, cnt_s}, 16'h0099);
        chk("sat_inc3_roll", {15'd0, roll_s}, 16'h0001);
        drive(1, 0, 16'h0000, 0, 0);
        step();
        chk("sat_clr_cnt", {8'h00, cnt_s}, 16'h0000);
        chk("sat_clr_roll", {15'd0, roll_s}, 16'h0000);
        drive(0, 0, 16'h0000, 0, 1);
        step();
        chk("sat_dec_cnt", {8'h00, cnt_s}, 16'h0000);
        chk("sat_dec_roll", {15'd0, roll_s}, 16'h0001);
        drive(0, 0, 16'h0000, 0, 0);
        step();
        chk("sat_idle_roll", {15'd0, roll_s}, 16'h0000);

        // Four-digit counter across the full carry/borrow chain.
        drive(0, 1, 16'h9999, 0, 0);
        step();
        chk("d4_ld9999", cnt_4, 16'h9999);
        drive(0, 0, 16'h0000, 1, 0);
        step();
        chk("d4_inc_cnt", cnt_4, 16'h0000);
        chk("d4_inc_roll", {15'd0, roll_4}, 16'h0001);
        drive(0, 0, 16'h0000, 0, 1);
        step();
        chk("d4_dec_cnt", cnt_4, 16'h9999);
        chk("d4_dec_roll", {15'd0, roll_4}, 16'h0001);
        drive(0, 1, 16'h1000, 0, 0);
        step();
        drive(0, 0, 16'h0000, 0, 1);
        step();
        chk("d4_borrow_chain", cnt_4, 16'h0999);
        chk("d4_borrow_roll", {15'd0, roll_4}, 16'h0000);
        drive(0, 1, 16'h3C07, 0, 0);
        step();
        chk("d4_ld_clamp", cnt_4, 16'h3907);
        chk("d4_ld_err", {15'd0, err_4}, 16'h0001);

        drive(0, 0, 16'h0000, 0, 0);
        step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_bcd_updown_cnt
`default_nettype wire
